serial_rx_deframer: RTL and testbench
=====================================

Name: serial_rx_deframer

Overview:
- Serial receiver that sits directly downstream of the FIFO-fed transmit path and consumes its `transmit_lane` output.
- Recovers 8N1-style frames (1 start bit low, DATA_BITS data bits LSB first, 1 stop bit high) from the serial line by counting clocks per bit.
- Presents each received word on a valid/ready output with a single-entry holding register.
- Flags framing errors and overruns for the consuming logic.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line; idles high; asynchronous to the bit timing.
- data_out  output  DATA_BITS  received word; stable while valid=1.
- valid  output  1  data_out holds an unconsumed word.
- ready  input  1  consumer accepts the word on a cycle where valid&ready=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a word completed while the holding register was full; the new word is dropped.

Behaviour:
- **Reset.** rst=1 at a clk edge forces:
  - state=IDLE, bit counter=0, clock counter=0, shift register=0.
  - rx synchronizer flops=1.
  - data_out=0, valid=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame; no flags are raised for it.
- **Input path.** rx passes through a 2-flop synchronizer; `rxs` is the second flop. All decisions use rxs.
- **States:** IDLE, START, DATA, STOP.
  - **IDLE.**
    - If rxs=0 and `armed`=1: go to START and clear the clock counter.
    - `armed` is set whenever rxs=1 is seen in IDLE and cleared on entering START. It is set to 1 at reset.
    - A line held low therefore never starts a second frame.
  - **START.**
    - Count CLKS_PER_BIT/2−1 further cycles, then sample rxs (mid-bit).
    - rxs=0: go to DATA, clear the counters.
    - rxs=1: false start; go back to IDLE with no flag.
  - **DATA.**
    - Every CLKS_PER_BIT cycles, sample rxs into the shift register MSB and shift right, so the first bit ends up in bit 0.
    - After DATA_BITS samples, go to STOP.
  - **STOP.** After CLKS_PER_BIT cycles, sample rxs, then go to IDLE in all cases.
    - rxs=1: word complete; see the output rules below.
    - rxs=0: frame_err=1 for exactly that cycle; the word is discarded and valid/data_out are unchanged.
- **Latency.** valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT clock edges after the first edge at which rx=0 is sampled. With defaults this is 154.
- **Output rules** (all evaluated on the completion cycle):
  - valid=0: load data_out and set valid=1.
  - valid=1 and ready=1: the old word is consumed; load the new word and keep valid=1. No overrun.
  - valid=1 and ready=0: overrun=1 for one cycle; data_out and valid are unchanged.
- **Handshake.**
  - valid&ready with no completion on the same cycle clears valid on the next edge.
  - ready while valid=0 has no effect.
  - data_out changes only on load or reset.
- **Receiver independence.** The receiver never stalls; reception continues regardless of ready.
- **Pulse exclusivity.** frame_err and overrun are never asserted on the same cycle.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
1. **Single word.** ready=1, send 0xA5 with stop=1 → data_out=0xA5, valid=1 exactly 154 cycles after the start edge, valid clears the next cycle, frame_err=0, overrun=0.
2. **Framing error.** Send 0x3C with the stop bit driven 0, then hold rx low for 3 bit times before raising it → frame_err pulses for 1 cycle at the stop sample, valid stays 0, and no second frame starts while rx is low.
3. **False start.** rx low for 4 cycles, then high → no valid and no frame_err. A following 0x5A frame is received correctly.
4. **Overrun.** ready=0, send 0x11 then 0x22 back-to-back → data_out=0x11, valid=1, and one overrun pulse at 0x22 completion. Raising ready then gives valid=0 with 0x11 the only word delivered.
5. **Simultaneous accept/load.** valid=1 with 0x00 held, ready asserted exactly on the 0xFF completion cycle → data_out=0xFF, valid stays 1, no overrun.
6. **Reset mid-frame.** Assert rst for 1 cycle during DATA bit 4 of 0xC3 → all outputs 0, no flags. A following 0x81 frame is received correctly.

Source files
------------

// File: rtl/serial_rx_deframer.sv
// Serial frame receiver: recovers start/data/stop frames from a single line
// by counting clocks per bit, and hands each received word to the consumer
// through a single-entry valid/ready holding register.
module serial_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CCW-1:0] HALF_LAST = CCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CCW-1:0] BIT_LAST  = CCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rxs;
  logic                 armed, armed_next;
  logic [CCW-1:0]       clk_cnt, clk_cnt_next;
  logic [BCW-1:0]       bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 word_done;
  logic                 stop_bad;

  // Two-flop synchronizer; the line idles high so the flops reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver state, bit timing counters, shift register and start-arming flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b1;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      armed     <= armed_next;
      clk_cnt   <= clk_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: a start edge is only accepted after the line has been
  // seen high in IDLE, so a line stuck low cannot start back-to-back frames.
  always_comb begin
    state_next   = state;
    armed_next   = armed;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    word_done    = 1'b0;
    stop_bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rxs) begin
          armed_next = 1'b1;
        end else if (armed) begin
          state_next   = START;
          armed_next   = 1'b0;
          clk_cnt_next = '0;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = rxs ? IDLE : DATA;
        end else begin
          clk_cnt_next = clk_cnt + CCW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rxs, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = STOP;
          end else begin
            bit_cnt_next = bit_cnt + BCW'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt + CCW'(1);
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
          if (rxs) begin
            word_done = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt + CCW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register: a completed word loads if the slot is empty or being
  // consumed this cycle, otherwise it is dropped and flagged as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (word_done) begin
        if (!valid || ready) begin
          data_out <= shift_reg;
          valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Self-checking bench for serial_rx_deframer: table-driven frames plus
// hand-written sequences for latency, framing, overrun and reset corners.
module tb_serial_rx_deframer;

  localparam int CPB     = 16;
  localparam int DB      = 8;
  localparam int LATENCY = 2 + CPB / 2 + (DB + 1) * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          ready;
  logic [DB-1:0] data_out;
  logic          valid;
  logic          frame_err;
  logic          overrun;

  int            checks = 0;
  int            errors = 0;
  int            ferr_count = 0;
  int            ovr_count = 0;
  logic          prev_ferr = 1'b0;
  logic          prev_ovr = 1'b0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] mon_exp;

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    logic          exp_word;
    logic          exp_ferr;
  } vec_t;

  vec_t vecs[8];

  serial_rx_deframer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting at a falling clock edge; a low stop bit can be
  // followed by extra low bit times before the line is released.
  task automatic applyStimulus(input logic [DB-1:0] d, input logic stop, input int tail_bits);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    if (!stop) repeat (tail_bits * CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Scoreboard monitor: every handshake pops the oldest expected word; pulses
  // are counted and checked for single-cycle width and mutual exclusion.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("delivered_word", data_out, mon_exp);
        end
      end
      if (frame_err) ferr_count++;
      if (overrun) ovr_count++;
      if (frame_err || overrun) checkOutput("pulse_exclusive", frame_err & overrun, 0);
      if (frame_err) checkOutput("ferr_one_cycle", prev_ferr, 0);
      if (overrun) checkOutput("ovr_one_cycle", prev_ovr, 0);
      prev_ferr = frame_err;
      prev_ovr  = overrun;
    end
  end

  initial begin
    int            ferr0;
    int            ovr0;
    int            lat;
    logic [DB-1:0] val_data;
    logic [DB-1:0] word;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h7E, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'h01, 1'b1, 1'b1, 1'b0};

    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_ferr", frame_err, 0);
    checkOutput("reset_ovr", overrun, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] single word latency");
    ready = 1'b1;
    ferr0 = ferr_count;
    ovr0  = ovr_count;
    exp_q.push_back(8'hA5);
    lat = -1;
    val_data = '0;
    fork
      applyStimulus(8'hA5, 1'b1, 0);
      begin
        for (int n = 0; n < 400; n++) begin
          @(posedge clk);
          #1;
          if (valid) begin
            lat = n;
            val_data = data_out;
            break;
          end
        end
      end
    join
    checkOutput("latency", lat, LATENCY);
    checkOutput("latency_data", val_data, 8'hA5);
    checkOutput("latency_valid_cleared", valid, 0);
    checkOutput("latency_ferr", ferr_count - ferr0, 0);
    checkOutput("latency_ovr", ovr_count - ovr0, 0);
    repeat (4) @(negedge clk);

    $display("[TB] table vectors");
    foreach (vecs[k]) begin
      ferr0 = ferr_count;
      ovr0  = ovr_count;
      if (vecs[k].exp_word) exp_q.push_back(vecs[k].data);
      applyStimulus(vecs[k].data, vecs[k].stop, 0);
      repeat (4) @(negedge clk);
      checkOutput("vec_ferr", ferr_count - ferr0, {31'd0, vecs[k].exp_ferr});
      checkOutput("vec_ovr", ovr_count - ovr0, 0);
      checkOutput("vec_drained", exp_q.size(), 0);
      checkOutput("vec_valid", valid, 0);
    end

    $display("[TB] framing error with line held low");
    ferr0 = ferr_count;
    applyStimulus(8'h3C, 1'b0, 3);
    repeat (250) @(negedge clk);
    checkOutput("ferr_low_count", ferr_count - ferr0, 1);
    checkOutput("ferr_low_valid", valid, 0);
    checkOutput("ferr_low_drained", exp_q.size(), 0);

    $display("[TB] false start");
    ferr0 = ferr_count;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("false_start_ferr", ferr_count - ferr0, 0);
    checkOutput("false_start_valid", valid, 0);
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1, 0);
    repeat (4) @(negedge clk);
    checkOutput("false_start_next", exp_q.size(), 0);
    checkOutput("false_start_next_data", data_out, 8'h5A);

    $display("[TB] overrun");
    ready = 1'b0;
    ferr0 = ferr_count;
    ovr0  = ovr_count;
    exp_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 0);
    applyStimulus(8'h22, 1'b1, 0);
    repeat (4) @(negedge clk);
    checkOutput("ovr_data", data_out, 8'h11);
    checkOutput("ovr_valid", valid, 1);
    checkOutput("ovr_count", ovr_count - ovr0, 1);
    checkOutput("ovr_ferr", ferr_count - ferr0, 0);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ovr_valid_after", valid, 0);
    checkOutput("ovr_drained", exp_q.size(), 0);

    $display("[TB] simultaneous accept and load");
    ready = 1'b0;
    ovr0  = ovr_count;
    exp_q.push_back(8'h00);
    applyStimulus(8'h00, 1'b1, 0);
    repeat (4) @(negedge clk);
    checkOutput("sim_hold_valid", valid, 1);
    exp_q.push_back(8'hFF);
    fork
      applyStimulus(8'hFF, 1'b1, 0);
      begin
        repeat (LATENCY) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    checkOutput("sim_data", data_out, 8'hFF);
    checkOutput("sim_valid", valid, 1);
    checkOutput("sim_ovr", ovr_count - ovr0, 0);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("sim_drained", exp_q.size(), 0);

    $display("[TB] reset mid-frame");
    ferr0 = ferr_count;
    ovr0  = ovr_count;
    word  = 8'hC3;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = word[i];
      repeat (CPB) @(negedge clk);
    end
    rx = word[4];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", valid, 0);
    checkOutput("midrst_data", data_out, 0);
    checkOutput("midrst_ferr", frame_err, 0);
    checkOutput("midrst_ovr", overrun, 0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (250) @(negedge clk);
    checkOutput("midrst_no_ferr", ferr_count - ferr0, 0);
    checkOutput("midrst_no_ovr", ovr_count - ovr0, 0);
    checkOutput("midrst_no_valid", valid, 0);
    exp_q.push_back(8'h81);
    applyStimulus(8'h81, 1'b1, 0);
    repeat (4) @(negedge clk);
    checkOutput("midrst_next", exp_q.size(), 0);
    checkOutput("midrst_next_data", data_out, 8'h81);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
